// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter
// Round-robin write-side arbiter in front of a single sync_fifo write port.
// A requester that wins the grant keeps it for up to MAX_BURST beats, or until
// it marks a beat with req_last. The arbiter holds no data, so the winning
// requester's data reaches the FIFO in the same cycle the beat is accepted.
//
//  state | meaning
//  ------+---------------------------------------------------------------
//  IDLE  | no grant held; round-robin pick runs and the winner moves its
//        | first beat in the same cycle
//  BURST | grant locked to owner_q until req_last or the beat limit; a
//        | stall (fifo_full or owner not valid) holds the grant

module fifo_wr_arbiter #(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 8,
    parameter int MAX_BURST  = 4
) (
    input  logic                            clk,
    input  logic                            aclr_n,
    input  logic                            sclr_n,
    input  logic [NUM_REQ-1:0]              req_valid,
    input  logic [NUM_REQ-1:0]              req_last,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]   req_data,
    output logic [NUM_REQ-1:0]              req_ready,
    input  logic                            fifo_full,
    output logic                            fifo_wr_en,
    output logic [DATA_WIDTH-1:0]           fifo_din,
    output logic                            lock,
    output logic [$clog2(NUM_REQ)-1:0]      owner_id,
    output logic                            burst_done
);

    localparam int OWN_W = $clog2(NUM_REQ);
    localparam int CNT_W = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;

    localparam logic [OWN_W-1:0] LAST_RST = OWN_W'(NUM_REQ - 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX_BURST - 1);

    typedef enum logic {
        IDLE  = 1'b0,
        BURST = 1'b1
    } state_t;

    state_t             state_q, state_d;
    logic [OWN_W-1:0]   owner_q, owner_d;
    logic [OWN_W-1:0]   last_q, last_d;
    logic [CNT_W-1:0]   beat_cnt_q, beat_cnt_d;
    logic               burst_done_q, burst_done_d;
    logic [OWN_W-1:0]   owner_id_q, owner_id_d;

    logic               rr_hit;
    logic [OWN_W-1:0]   rr_idx;
    logic [OWN_W-1:0]   cand;
    logic [OWN_W-1:0]   owner;
    logic               owner_vld;
    logic               xfer;
    logic               release_burst;

    // Round-robin search: first valid requester after the last released owner.
    always_comb begin
        rr_hit = 1'b0;
        rr_idx = '0;
        cand   = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            cand = OWN_W'((int'(last_q) + k) % NUM_REQ);
            if (!rr_hit && req_valid[cand]) begin
                rr_hit = 1'b1;
                rr_idx = cand;
            end
        end
    end

    // Owner select and transfer qualification; nothing is granted while aclr_n is low.
    always_comb begin
        owner     = rr_idx;
        owner_vld = rr_hit;
        if (state_q == BURST) begin
            owner     = owner_q;
            owner_vld = 1'b1;
        end
        owner_vld     = owner_vld && aclr_n;
        xfer          = owner_vld && req_valid[owner] && !fifo_full;
        release_burst = req_last[owner] || (beat_cnt_q == CNT_LAST);
    end

    // Zero-latency write path: owner's data and a one-hot ready on transfer.
    always_comb begin
        fifo_din  = '0;
        req_ready = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (owner_vld && (owner == OWN_W'(i))) begin
                fifo_din     = req_data[i*DATA_WIDTH +: DATA_WIDTH];
                req_ready[i] = xfer;
            end
        end
        fifo_wr_en = xfer;
    end

    // Next-state: burst tracking, release bookkeeping and synchronous clear.
    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        last_d       = last_q;
        beat_cnt_d   = beat_cnt_q;
        burst_done_d = 1'b0;
        owner_id_d   = owner_id_q;

        if (xfer) begin
            owner_id_d = owner;
            if (release_burst) begin
                state_d      = IDLE;
                last_d       = owner;
                beat_cnt_d   = '0;
                burst_done_d = 1'b1;
            end else begin
                state_d    = BURST;
                owner_d    = owner;
                beat_cnt_d = beat_cnt_q + 1'b1;
            end
        end

        // Clearing last_q to NUM_REQ-1 makes requester 0 the first candidate.
        if (!sclr_n) begin
            state_d      = IDLE;
            owner_d      = '0;
            last_d       = LAST_RST;
            beat_cnt_d   = '0;
            burst_done_d = 1'b0;
            owner_id_d   = '0;
        end
    end

    // State register with asynchronous clear.
    always_ff @(posedge clk or negedge aclr_n) begin
        if (!aclr_n) begin
            state_q      <= IDLE;
            owner_q      <= '0;
            last_q       <= LAST_RST;
            beat_cnt_q   <= '0;
            burst_done_q <= 1'b0;
            owner_id_q   <= '0;
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            last_q       <= last_d;
            beat_cnt_q   <= beat_cnt_d;
            burst_done_q <= burst_done_d;
            owner_id_q   <= owner_id_d;
        end
    end

    assign lock       = (state_q == BURST);
    assign owner_id   = owner_id_q;
    assign burst_done = burst_done_q;

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed bench for fifo_wr_arbiter: expected beats are queued as each step
// is driven and consumed when the DUT writes the FIFO.

module tb_fifo_wr_arbiter;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        aclr_n, sclr_n;
    logic [3:0]  req_valid, req_last, req_ready;
    logic [31:0] req_data;
    logic        fifo_full, fifo_wr_en;
    logic [7:0]  fifo_din;
    logic        lock, burst_done;
    logic [1:0]  owner_id;

    logic [2:0]  valid_b, last_b, ready_b;
    logic [23:0] data_b;
    logic        full_b, wr_en_b, lock_b, done_b;
    logic [7:0]  din_b;
    logic [1:0]  owner_id_b;

    fifo_wr_arbiter #(.NUM_REQ(4), .DATA_WIDTH(8), .MAX_BURST(4)) dut (
        .clk(clk), .aclr_n(aclr_n), .sclr_n(sclr_n),
        .req_valid(req_valid), .req_last(req_last), .req_data(req_data),
        .req_ready(req_ready), .fifo_full(fifo_full), .fifo_wr_en(fifo_wr_en),
        .fifo_din(fifo_din), .lock(lock), .owner_id(owner_id), .burst_done(burst_done)
    );

    fifo_wr_arbiter #(.NUM_REQ(3), .DATA_WIDTH(8), .MAX_BURST(2)) dut_b (
        .clk(clk), .aclr_n(aclr_n), .sclr_n(sclr_n),
        .req_valid(valid_b), .req_last(last_b), .req_data(data_b),
        .req_ready(ready_b), .fifo_full(full_b), .fifo_wr_en(wr_en_b),
        .fifo_din(din_b), .lock(lock_b), .owner_id(owner_id_b), .burst_done(done_b)
    );

    typedef struct {
        int         owner;
        logic [7:0] data;
    } beat_t;

    beat_t sb[$];
    int    total = 0;
    int    passed = 0;
    int    seq[4];
    int    exp_seq[4];
    int    model_oid = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic drive_data();
        for (int i = 0; i < 4; i++) req_data[i*8 +: 8] = 8'(i*16 + seq[i]);
    endtask

    // One clock: drive inputs, queue the expected beat (eo<0: none), check at negedge.
    task automatic step(input logic [3:0] v, input logic [3:0] l, input logic f,
                        input int eo, input logic el, input logic ed);
        beat_t b;
        req_valid = v;
        req_last  = l;
        fifo_full = f;
        if (eo >= 0) begin
            b.owner = eo;
            b.data  = 8'(eo*16 + exp_seq[eo]);
            exp_seq[eo]++;
            sb.push_back(b);
        end
        @(negedge clk);
        chk("lock", lock, el);
        chk("burst_done", burst_done, ed);
        chk("owner_id", 32'(owner_id), model_oid);
        chk("wr_en", fifo_wr_en, eo >= 0);
        if (fifo_wr_en === 1'b1 && sb.size() > 0) begin
            b = sb.pop_front();
            chk("din", fifo_din, b.data);
            chk("ready", req_ready, 1 << b.owner);
        end else begin
            chk("ready_idle", req_ready, 0);
        end
        for (int i = 0; i < 4; i++) if (req_ready[i] === 1'b1) seq[i]++;
        if (eo >= 0) model_oid = eo;
        @(posedge clk);
        #1;
        drive_data();
    endtask

    int ord_b[7]  = '{0, 0, 1, 1, 2, 2, 0};
    int lock_pb[7] = '{0, 1, 0, 1, 0, 1, 0};

    initial begin
        aclr_n = 1'b0; sclr_n = 1'b1;
        req_valid = 4'hF; req_last = 4'h0; fifo_full = 1'b0;
        for (int i = 0; i < 4; i++) begin seq[i] = 0; exp_seq[i] = 0; end
        drive_data();
        valid_b = '0; last_b = '0; full_b = 1'b0;
        data_b = {8'hA2, 8'hA1, 8'hA0};

        // Reset state, with every requester valid to show the outputs are gated.
        #1;
        chk("rst_wr_en", fifo_wr_en, 0);
        chk("rst_ready", req_ready, 0);
        chk("rst_lock", lock, 0);
        chk("rst_done", burst_done, 0);
        chk("rst_owner_id", 32'(owner_id), 0);
        req_valid = 4'h0;
        repeat (2) @(posedge clk);
        #3 aclr_n = 1'b1;
        @(posedge clk);
        #1;

        // 1: all valid, no last -> four 4-beat bursts in order 0,1,2,3.
        for (int r = 0; r < 4; r++)
            for (int k = 0; k < 4; k++)
                step(4'b1111, 4'b0000, 1'b0, r, k != 0, (k == 0) && (r != 0));

        // 2: single-beat bursts alternate between requesters 0 and 2.
        for (int k = 0; k < 4; k++)
            step(4'b0101, 4'b0101, 1'b0, (k % 2) ? 2 : 0, 1'b0, 1'b1);

        // 3: requester 1 stalled by fifo_full; requester 2 must wait.
        step(4'b0110, 4'b0000, 1'b0, 1, 1'b0, 1'b1);
        step(4'b0110, 4'b0000, 1'b0, 1, 1'b1, 1'b0);
        repeat (3) step(4'b0110, 4'b0000, 1'b1, -1, 1'b1, 1'b0);
        step(4'b0110, 4'b0000, 1'b0, 1, 1'b1, 1'b0);
        step(4'b0110, 4'b0000, 1'b0, 1, 1'b1, 1'b0);

        // 4: requester 3 drops valid mid-burst; requester 0 is ignored.
        step(4'b1000, 4'b0000, 1'b0, 3, 1'b0, 1'b1);
        repeat (2) step(4'b0001, 4'b0000, 1'b0, -1, 1'b1, 1'b0);
        step(4'b1001, 4'b0000, 1'b0, 3, 1'b1, 1'b0);
        step(4'b1001, 4'b0000, 1'b0, 3, 1'b1, 1'b0);
        step(4'b1001, 4'b0000, 1'b0, 3, 1'b1, 1'b0);
        step(4'b0000, 4'b0000, 1'b0, -1, 1'b0, 1'b1);

        // 5: asynchronous clear in the middle of requester 2's burst.
        step(4'b0100, 4'b0000, 1'b0, 2, 1'b0, 1'b0);
        step(4'b0100, 4'b0000, 1'b0, 2, 1'b1, 1'b0);
        req_valid = 4'b1111;
        #2 aclr_n = 1'b0;
        #1;
        chk("aclr_wr_en", fifo_wr_en, 0);
        chk("aclr_ready", req_ready, 0);
        chk("aclr_din", fifo_din, 0);
        chk("aclr_lock", lock, 0);
        chk("aclr_owner_id", 32'(owner_id), 0);
        req_valid = 4'b0000;
        model_oid = 0;
        @(posedge clk);
        #3 aclr_n = 1'b1;
        @(posedge clk);
        #1;
        step(4'b1111, 4'b0000, 1'b0, 0, 1'b0, 1'b0);
        step(4'b1111, 4'b0000, 1'b0, 0, 1'b1, 1'b0);
        step(4'b1111, 4'b0000, 1'b0, 0, 1'b1, 1'b0);
        step(4'b1111, 4'b0000, 1'b0, 0, 1'b1, 1'b0);
        step(4'b1111, 4'b0000, 1'b0, 1, 1'b0, 1'b1);
        step(4'b1111, 4'b0000, 1'b0, 1, 1'b1, 1'b0);

        // Synchronous clear mid-burst of requester 1: next grant restarts at 0.
        sclr_n = 1'b0;
        step(4'b0000, 4'b0000, 1'b0, -1, 1'b1, 1'b0);
        sclr_n = 1'b1;
        model_oid = 0;
        step(4'b1101, 4'b0000, 1'b0, 0, 1'b0, 1'b0);
        step(4'b0000, 4'b0000, 1'b0, -1, 1'b1, 1'b0);

        // 6: three requesters, two-beat bursts, grant order wraps back to 0.
        valid_b = 3'b111;
        for (int k = 0; k < 7; k++) begin
            @(negedge clk);
            chk("b_wr_en", wr_en_b, 1);
            chk("b_ready", ready_b, 1 << ord_b[k]);
            chk("b_din", din_b, 8'hA0 + 8'(ord_b[k]));
            chk("b_lock", lock_b, lock_pb[k]);
            @(posedge clk);
            #1;
        end
        valid_b = 3'b000;

        chk("sb_drained", sb.size(), 0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
